// File: rtl/pll_reconfig_pkg.sv
// Shared types, register map and write-table lookup for the PLL reconfiguration sequencer.
package pll_reconfig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WRITE    = 3'd1,
    ST_GAP      = 3'd2,
    ST_PRST     = 3'd3,
    ST_LOCKWAIT = 3'd4
  } state_t;

  // Management register map of the reconfig IP
  localparam logic [5:0] ADDR_MODE  = 6'd0;
  localparam logic [5:0] ADDR_START = 6'd2;
  localparam logic [5:0] ADDR_N     = 6'd3;
  localparam logic [5:0] ADDR_M     = 6'd4;
  localparam logic [5:0] ADDR_C     = 6'd5;
  localparam logic [5:0] ADDR_K     = 6'd7;
  localparam logic [5:0] ADDR_BW    = 6'd8;
  localparam logic [5:0] ADDR_CP    = 6'd9;

  // Index of the last write in the table
  localparam logic [2:0] LAST_IDX = 3'd7;

  typedef logic [2:0] widx_t;

  typedef struct packed {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_entry_t;

  // Fixed eight-write reconfiguration table: mode, M, K, N, C0, CP, BW, start
  function automatic wr_entry_t table_lookup(
    input widx_t       idx,
    input logic [31:0] m,
    input logic [31:0] k,
    input logic [31:0] c0,
    input logic [31:0] n_word,
    input logic [31:0] cp_word,
    input logic [31:0] bw_word
  );
    wr_entry_t e;
    case (idx)
      3'd0:    begin e.addr = ADDR_MODE;  e.data = 32'd0;   end
      3'd1:    begin e.addr = ADDR_M;     e.data = m;       end
      3'd2:    begin e.addr = ADDR_K;     e.data = k;       end
      3'd3:    begin e.addr = ADDR_N;     e.data = n_word;  end
      3'd4:    begin e.addr = ADDR_C;     e.data = c0;      end
      3'd5:    begin e.addr = ADDR_CP;    e.data = cp_word; end
      3'd6:    begin e.addr = ADDR_BW;    e.data = bw_word; end
      default: begin e.addr = ADDR_START; e.data = 32'd0;   end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/pll_reconfig_seq.sv
// Runs one full PLL reconfiguration: eight management writes, a PLL reset pulse,
// then a bounded wait for the (synchronized) lock indication.
module pll_reconfig_seq
  import pll_reconfig_pkg::*;
#(
  parameter int          GAP_CYCLES   = 7,
  parameter int          RST_CYCLES   = 8,
  parameter int          LOCK_TIMEOUT = 5000000,
  parameter logic [31:0] N_WORD       = 32'h00010000,
  parameter logic [31:0] CP_WORD      = 32'd1,
  parameter logic [31:0] BW_WORD      = 32'd7
) (
  input  logic        CLK_50M,
  input  logic        RESET,
  input  logic        req,
  input  logic [31:0] m_val,
  input  logic [31:0] k_val,
  input  logic [31:0] c0_val,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  mgmt_address,
  output logic [31:0] mgmt_writedata,
  output logic        mgmt_write,
  input  logic        mgmt_waitrequest,
  output logic        pll_reset,
  input  logic        locked
);

  // Parameters must fit their counters
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("GAP_CYCLES must be in 0..255");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > 256) begin : g_bad_rst
    $error("RST_CYCLES must be in 1..256");
  end
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > (1 << 23)) begin : g_bad_to
    $error("LOCK_TIMEOUT must be in 1..2**23");
  end

  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);
  localparam logic [7:0]  RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [22:0] TO_LAST  = 23'(LOCK_TIMEOUT - 1);

  state_t      state_reg, state_next;
  widx_t       idx_reg, idx_next;
  logic [7:0]  gap_cnt_reg, gap_cnt_next;
  logic [7:0]  rst_cnt_reg, rst_cnt_next;
  logic [22:0] to_cnt_reg, to_cnt_next;
  logic [31:0] m_reg, m_next, k_reg, k_next, c0_reg, c0_next;
  logic [31:0] m_sh_reg, m_sh_next, k_sh_reg, k_sh_next, c0_sh_reg, c0_sh_next;
  logic        pending_reg, pending_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        error_reg, error_next;
  logic        lk_meta_reg, lk_s_reg;
  logic        finished;
  wr_entry_t   entry;

  // Two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      lk_meta_reg <= 1'b0;
      lk_s_reg    <= 1'b0;
    end else begin
      lk_meta_reg <= locked;
      lk_s_reg    <= lk_meta_reg;
    end
  end

  // State and datapath register update
  always_ff @(posedge CLK_50M) begin
    if (RESET) begin
      state_reg   <= ST_IDLE;
      idx_reg     <= '0;
      gap_cnt_reg <= '0;
      rst_cnt_reg <= '0;
      to_cnt_reg  <= '0;
      m_reg       <= '0;
      k_reg       <= '0;
      c0_reg      <= '0;
      m_sh_reg    <= '0;
      k_sh_reg    <= '0;
      c0_sh_reg   <= '0;
      pending_reg <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      error_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      gap_cnt_reg <= gap_cnt_next;
      rst_cnt_reg <= rst_cnt_next;
      to_cnt_reg  <= to_cnt_next;
      m_reg       <= m_next;
      k_reg       <= k_next;
      c0_reg      <= c0_next;
      m_sh_reg    <= m_sh_next;
      k_sh_reg    <= k_sh_next;
      c0_sh_reg   <= c0_sh_next;
      pending_reg <= pending_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      error_reg   <= error_next;
    end
  end

  assign finished = lk_s_reg || (to_cnt_reg == TO_LAST);

  // Next-state logic: sequence progression, request capture and completion
  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    gap_cnt_next = gap_cnt_reg;
    rst_cnt_next = rst_cnt_reg;
    to_cnt_next  = to_cnt_reg;
    m_next       = m_reg;
    k_next       = k_reg;
    c0_next      = c0_reg;
    m_sh_next    = m_sh_reg;
    k_sh_next    = k_sh_reg;
    c0_sh_next   = c0_sh_reg;
    pending_next = pending_reg;
    busy_next    = busy_reg;
    done_next    = 1'b0;
    error_next   = error_reg;

    // A request during a running sequence is queued; the latest one wins
    if (req && state_reg != ST_IDLE) begin
      pending_next = 1'b1;
      m_sh_next    = m_val;
      k_sh_next    = k_val;
      c0_sh_next   = c0_val;
    end

    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          m_next     = m_val;
          k_next     = k_val;
          c0_next    = c0_val;
          error_next = 1'b0;
          busy_next  = 1'b1;
          idx_next   = '0;
          state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (!mgmt_waitrequest) begin
          if (GAP_CYCLES == 0) begin
            if (idx_reg == LAST_IDX) begin
              rst_cnt_next = '0;
              state_next   = ST_PRST;
            end else begin
              idx_next = idx_reg + 3'd1;
            end
          end else begin
            gap_cnt_next = '0;
            state_next   = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          if (idx_reg == LAST_IDX) begin
            rst_cnt_next = '0;
            state_next   = ST_PRST;
          end else begin
            idx_next   = idx_reg + 3'd1;
            state_next = ST_WRITE;
          end
        end else begin
          gap_cnt_next = gap_cnt_reg + 8'd1;
        end
      end
      ST_PRST: begin
        if (rst_cnt_reg == RST_LAST) begin
          to_cnt_next = '0;
          state_next  = ST_LOCKWAIT;
        end else begin
          rst_cnt_next = rst_cnt_reg + 8'd1;
        end
      end
      ST_LOCKWAIT: begin
        if (finished) begin
          done_next = lk_s_reg;
          if (!lk_s_reg) begin
            error_next = 1'b1;
          end
          // A queued request (or one arriving right now) restarts immediately
          if (pending_reg || req) begin
            m_next       = req ? m_val  : m_sh_reg;
            k_next       = req ? k_val  : k_sh_reg;
            c0_next      = req ? c0_val : c0_sh_reg;
            pending_next = 1'b0;
            idx_next     = '0;
            state_next   = ST_WRITE;
          end else begin
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end
        end else begin
          to_cnt_next = to_cnt_reg + 23'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign entry          = table_lookup(idx_reg, m_reg, k_reg, c0_reg, N_WORD, CP_WORD, BW_WORD);
  assign mgmt_write     = (state_reg == ST_WRITE);
  assign mgmt_address   = mgmt_write ? entry.addr : 6'd0;
  assign mgmt_writedata = mgmt_write ? entry.data : 32'd0;
  assign pll_reset      = (state_reg == ST_PRST);
  assign busy           = busy_reg;
  assign done           = done_reg;
  assign error          = error_reg;

endmodule

// File: tb/tb_pll_reconfig_seq.sv
// Scoreboard bench for pll_reconfig_seq: expected management writes are queued
// when a request is driven and compared as the DUT issues them.
module tb_pll_reconfig_seq;

  localparam int GAP_C    = 7;
  localparam int RST_C    = 8;
  localparam int LOCK_T   = 300;
  localparam int DONE_LAT = 22;   // 20 cycles to lock + 2 synchronizer stages

  logic        clk = 1'b0;
  logic        RESET;
  logic        req;
  logic [31:0] m_val, k_val, c0_val;
  logic        busy, done, error;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;
  logic        pll_reset;
  logic        locked;

  int n_checks = 0;
  int n_pass   = 0;

  logic [37:0] exp_q[$];
  logic        exp_pending = 1'b0;
  logic [31:0] sh_m, sh_k, sh_c0;

  int cyc = 0, done_cnt = 0, err_cnt = 0, wr_cnt = 0;
  int seq_pos = 0, wr_len = 0, last_acc_cyc = 0, fall_cyc = 0, prst_len = 0;
  int len_by_pos [8];
  logic prev_write = 1'b0, prev_prst = 1'b0, prev_err = 1'b0;
  logic lock_enable = 1'b1;

  pll_reconfig_seq #(
    .GAP_CYCLES  (GAP_C),
    .RST_CYCLES  (RST_C),
    .LOCK_TIMEOUT(LOCK_T)
  ) dut (
    .CLK_50M         (clk),
    .RESET           (RESET),
    .req             (req),
    .m_val           (m_val),
    .k_val           (k_val),
    .c0_val          (c0_val),
    .busy            (busy),
    .done            (done),
    .error           (error),
    .mgmt_address    (mgmt_address),
    .mgmt_writedata  (mgmt_writedata),
    .mgmt_write      (mgmt_write),
    .mgmt_waitrequest(mgmt_waitrequest),
    .pll_reset       (pll_reset),
    .locked          (locked)
  );

  always #10 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_seq(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0);
    exp_q.push_back({6'd0, 32'd0});
    exp_q.push_back({6'd4, m});
    exp_q.push_back({6'd7, k});
    exp_q.push_back({6'd3, 32'h0001_0000});
    exp_q.push_back({6'd5, c0});
    exp_q.push_back({6'd9, 32'd1});
    exp_q.push_back({6'd8, 32'd7});
    exp_q.push_back({6'd2, 32'd0});
  endtask

  // One-cycle request; pend=1 when the bench knows the block is busy
  task automatic drive_req(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0, input logic pend);
    req = 1'b1; m_val = m; k_val = k; c0_val = c0;
    if (pend) begin
      exp_pending = 1'b1; sh_m = m; sh_k = k; sh_c0 = c0;
    end else begin
      push_seq(m, k, c0);
    end
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && done_cnt < target; i++) tick();
    check_eq("done_count", done_cnt, target);
  endtask

  // PLL model: lock drops during reset, returns on the 20th edge after release
  initial begin
    int cnt;
    logic armed;
    cnt = 0; armed = 1'b0; locked = 1'b1;
    forever begin
      tick();
      if (pll_reset === 1'b1) begin
        locked = 1'b0; cnt = 0; armed = 1'b1;
      end else if (armed) begin
        if (cnt >= 19 && lock_enable) begin
          locked = 1'b1; armed = 1'b0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Output monitor and scoreboard comparison, sampled mid-cycle
  initial begin
    logic [37:0] e;
    forever begin
      @(negedge clk);
      cyc++;
      if (RESET) begin
        seq_pos = 0; wr_len = 0; prst_len = 0;
        prev_write = 1'b0; prev_prst = 1'b0; prev_err = error;
      end else begin
        if (done) begin
          done_cnt++;
          $display("done  cyc=%0d busy=%0b", cyc, busy);
          check_eq("done_latency", cyc - fall_cyc, DONE_LAT);
          check_eq("busy_at_done", busy, exp_pending);
          if (exp_pending) begin push_seq(sh_m, sh_k, sh_c0); exp_pending = 1'b0; end
        end
        if (error && !prev_err) begin
          err_cnt++;
          $display("error cyc=%0d busy=%0b", cyc, busy);
          check_eq("timeout_latency", cyc - fall_cyc, LOCK_T);
          check_eq("busy_at_error", busy, exp_pending);
          if (exp_pending) begin push_seq(sh_m, sh_k, sh_c0); exp_pending = 1'b0; end
        end
        prev_err = error;
        if (pll_reset) prst_len++;
        else if (prev_prst) begin
          check_eq("prst_width", prst_len, RST_C);
          fall_cyc = cyc; prst_len = 0;
        end
        prev_prst = pll_reset;
        if (mgmt_write) begin
          if (!prev_write && seq_pos != 0) check_eq("gap_len", cyc - last_acc_cyc, GAP_C + 1);
          wr_len++;
          check_eq("sb_nonempty", exp_q.size() > 0, 1'b1);
          if (exp_q.size() > 0) begin
            e = exp_q[0];
            check_eq("wr_addr", mgmt_address, e[37:32]);
            check_eq("wr_data", mgmt_writedata, e[31:0]);
          end
          if (!mgmt_waitrequest) begin
            $display("write cyc=%0d idx=%0d addr=%0d data=0x%08h", cyc, seq_pos, mgmt_address, mgmt_writedata);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            wr_cnt++;
            len_by_pos[seq_pos] = wr_len;
            wr_len = 0; last_acc_cyc = cyc;
            seq_pos = (seq_pos + 1) % 8;
          end
        end
        prev_write = mgmt_write;
      end
    end
  end

  initial begin
    int w0, d0;
    RESET = 1'b1; req = 1'b0; m_val = '0; k_val = '0; c0_val = '0; mgmt_waitrequest = 1'b0;
    repeat (3) tick();
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_error", error, 1'b0);
    check_eq("rst_write", mgmt_write, 1'b0);
    check_eq("rst_addr", mgmt_address, 6'd0);
    check_eq("rst_data", mgmt_writedata, 32'd0);
    check_eq("rst_pll_reset", pll_reset, 1'b0);
    RESET = 1'b0;
    repeat (2) tick();

    // Basic sequence
    w0 = wr_cnt;
    drive_req(32'h167, 32'h808, 32'h20302, 1'b0);
    check_eq("capture_busy", busy, 1'b1);
    check_eq("first_write", mgmt_write, 1'b1);
    wait_done(1, 400);
    check_eq("basic_writes", wr_cnt - w0, 8);
    check_eq("basic_len_idx2", len_by_pos[2], 1);
    check_eq("basic_busy_after", busy, 1'b0);

    // Back-pressure on write idx 2
    repeat (3) tick();
    w0 = wr_cnt;
    drive_req(32'h167, 32'h808, 32'h20302, 1'b0);
    for (int i = 0; i < 100 && seq_pos != 2; i++) tick();
    mgmt_waitrequest = 1'b1;
    for (int i = 0; i < 100 && !mgmt_write; i++) tick();
    repeat (4) tick();
    tick();
    mgmt_waitrequest = 1'b0;
    wait_done(2, 400);
    check_eq("bp_len_idx2", len_by_pos[2], 6);
    check_eq("bp_writes", wr_cnt - w0, 8);

    // Lock timeout
    repeat (3) tick();
    lock_enable = 1'b0;
    d0 = done_cnt;
    drive_req(32'h11, 32'h22, 32'h33, 1'b0);
    for (int i = 0; i < LOCK_T + 300 && err_cnt < 1; i++) tick();
    check_eq("timeout_seen", err_cnt, 1);
    check_eq("timeout_no_done", done_cnt, d0);
    check_eq("timeout_error", error, 1'b1);
    check_eq("timeout_busy", busy, 1'b0);
    lock_enable = 1'b1;
    repeat (3) tick();
    drive_req(32'h167, 32'h808, 32'h20302, 1'b0);
    check_eq("req_clears_error", error, 1'b0);
    check_eq("req_sets_busy", busy, 1'b1);
    wait_done(d0 + 1, 400);

    // Pending requests: one in GAP, one in PRST, last wins
    repeat (3) tick();
    w0 = wr_cnt; d0 = done_cnt;
    drive_req(32'h100, 32'h808, 32'h20302, 1'b0);
    for (int i = 0; i < 100 && !(seq_pos >= 1 && !mgmt_write); i++) tick();
    drive_req(32'h150, 32'h909, 32'h30303, 1'b1);
    for (int i = 0; i < 200 && !pll_reset; i++) tick();
    drive_req(32'h145, 32'h707, 32'h10101, 1'b1);
    wait_done(d0 + 2, 600);
    repeat (60) tick();
    check_eq("pend_writes", wr_cnt - w0, 16);
    check_eq("pend_dones", done_cnt - d0, 2);
    check_eq("pend_idle", busy, 1'b0);

    // Reset during a stalled write
    mgmt_waitrequest = 1'b1;
    drive_req(32'h55, 32'h66, 32'h77, 1'b0);
    for (int i = 0; i < 20 && !mgmt_write; i++) tick();
    tick();
    RESET = 1'b1;
    tick();
    check_eq("mid_rst_write", mgmt_write, 1'b0);
    check_eq("mid_rst_addr", mgmt_address, 6'd0);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_pll_reset", pll_reset, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    RESET = 1'b0; mgmt_waitrequest = 1'b0;
    exp_q.delete(); exp_pending = 1'b0;
    repeat (3) tick();
    w0 = wr_cnt; d0 = done_cnt;
    drive_req(32'h167, 32'h808, 32'h20302, 1'b0);
    wait_done(d0 + 1, 400);
    check_eq("post_rst_writes", wr_cnt - w0, 8);

    // Request on the completion cycle
    repeat (3) tick();
    d0 = done_cnt;
    drive_req(32'h1a0, 32'h808, 32'h20302, 1'b0);
    for (int i = 0; i < 200 && !pll_reset; i++) tick();
    for (int i = 0; i < 20 && pll_reset; i++) tick();
    repeat (DONE_LAT - 1) tick();
    drive_req(32'h1b0, 32'h818, 32'h20312, 1'b1);
    check_eq("sim_done", done, 1'b1);
    check_eq("sim_busy", busy, 1'b1);
    check_eq("sim_restart", mgmt_write, 1'b1);
    wait_done(d0 + 2, 400);
    repeat (40) tick();
    check_eq("sim_dones", done_cnt - d0, 2);
    check_eq("sb_drained", exp_q.size(), 0);
    check_eq("final_busy", busy, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
